trng_stream_ctrl: RTL

Parametrised capture-and-stream controller between the `TRNG` entropy source and the `uart` transmitter. On a start pulse it samples the TRNG word on a synchronous divided-rate enable and buffers the samples in an internal FIFO. It then serialises exactly `TOTAL_BITS` of entropy to the UART, either as ASCII `'0'`/`'1'` characters or as raw bytes. It replaces the fixed 8-bit, single-mode, ripple-divided capture path in the top level.

---
 rtl/trng_pkg.sv | 10 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/trng_stream_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG capture-and-stream path.
package trng_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, ARM, WAIT} stream_state_t;
  typedef enum logic {MODE_ASCII, MODE_RAW} stream_mode_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered push/pop; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/trng_stream_ctrl.sv
// Captures TRNG words on a divided-rate enable into a FIFO and streams
// them to the UART as ASCII bit characters or raw bytes.
module trng_stream_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int TOTAL_BITS = 1000000,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_DIV = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int NWORDS = TOTAL_BITS / WORD_WIDTH;
  localparam int PCW    = $clog2(NWORDS + 1);
  localparam int BIW    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int SCW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  stream_state_t         state_q, state_d;
  stream_mode_t          mode_q, mode_d;
  logic [PCW-1:0]        push_cnt_q, push_cnt_d;
  logic [SCW-1:0]        samp_cnt_q, samp_cnt_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic                  start_acc, producing, sample_wrap, all_pushed, last_byte;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_dout;
  logic [7:0]            raw_byte;

  sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (word_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Raw mode requires WORD_WIDTH to be a byte multiple; narrower words only stream ASCII.
  generate
    if (WORD_WIDTH >= 8) begin : g_raw
      assign raw_byte = shift_q[WORD_WIDTH-1 -: 8];
    end else begin : g_no_raw
      assign raw_byte = 8'h00;
    end
  endgenerate

  always_comb begin
    start_acc   = start && !busy_q;
    all_pushed  = (push_cnt_q == PCW'(NWORDS));
    producing   = busy_q && !all_pushed;
    sample_wrap = producing && (samp_cnt_q == SCW'(SAMPLE_DIV - 1));
    fifo_pop    = (state_q == LOAD) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    fifo_push   = sample_wrap && (!fifo_full || fifo_pop);
    last_byte   = (mode_q == MODE_RAW) ? (byte_idx_q == BIW'(WORD_WIDTH / 8 - 1))
                                       : (byte_idx_q == BIW'(WORD_WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ASCII;
      push_cnt_q <= '0;
      samp_cnt_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      push_cnt_q <= push_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    push_cnt_d = push_cnt_q;
    samp_cnt_d = samp_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;

    if (start_acc) begin
      mode_d     = stream_mode_t'(mode);
      push_cnt_d = '0;
      samp_cnt_d = '0;
      overflow_d = 1'b0;
      busy_d     = 1'b1;
    end else if (producing) begin
      samp_cnt_d = sample_wrap ? '0 : samp_cnt_q + 1'b1;
      if (fifo_push) begin
        push_cnt_d = push_cnt_q + 1'b1;
      end else if (sample_wrap) begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_acc) state_d = LOAD;
      end
      LOAD: begin
        if (!fifo_empty) begin
          shift_d    = fifo_dout;
          byte_idx_d = '0;
          state_d    = SEND;
        end else if (all_pushed) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SEND: state_d = ARM;
      ARM:  state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_d = LOAD;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = (mode_q == MODE_RAW) ? (shift_q << 8) : (shift_q << 1);
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_wr    = (state_q == SEND);
    tx_data  = 8'h00;
    if (tx_wr) begin
      tx_data = (mode_q == MODE_RAW) ? raw_byte
                                     : (shift_q[WORD_WIDTH-1] ? ASCII_ONE : ASCII_ZERO);
    end
    done     = (state_q == LOAD) && fifo_empty && all_pushed;
    busy     = busy_q;
    overflow = overflow_q;
  end

endmodule
